// File: rtl/noc_bfm_types_pkg.sv
// Shared NoC BFM flit types plus the field offsets and arbiter FSM encoding
// used by the flit arbiter.
package noc_bfm_types_pkg;

    localparam int NOC_FLIT_DATA_W = 16;

    typedef enum logic {
        FLIT_PAYLOAD = 1'b0,
        FLIT_HEAD    = 1'b1
    } noc_bfm_flit_type;

    typedef struct packed {
        noc_bfm_flit_type        flit_type;
        logic                    tail;
        logic [NOC_FLIT_DATA_W-1:0] data;
    } noc_bfm_flit;

    localparam int NOC_FLIT_W        = $bits(noc_bfm_flit);
    localparam int NOC_FLIT_TYPE_BIT = NOC_FLIT_W - 1;
    localparam int NOC_FLIT_TAIL_BIT = NOC_FLIT_W - 2;

    // Tail sits just below the type MSB whatever the flit width is.
    function automatic int noc_flit_tail_bit(input int flit_w);
        return flit_w - 2;
    endfunction

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_flit_arbiter_if.sv
// Flit channel bundle between CHANNELS requesters and one shared output;
// signal directions are named from the arbiter's point of view.
interface noc_flit_arbiter_if
    import noc_bfm_types_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int FLIT_WIDTH = $bits(noc_bfm_flit)
);
    logic [CHANNELS-1:0]            i_valid;
    logic [CHANNELS-1:0]            o_ready;
    logic [CHANNELS*FLIT_WIDTH-1:0] i_flit;
    logic                           o_valid;
    logic                           i_ready;
    logic [FLIT_WIDTH-1:0]          o_flit;
    logic [CHANNELS-1:0]            o_grant;

    modport slave (
        input  i_valid, i_flit, i_ready,
        output o_ready, o_valid, o_flit, o_grant
    );

    modport master (
        output i_valid, i_flit, i_ready,
        input  o_ready, o_valid, o_flit, o_grant
    );
endinterface

// File: rtl/noc_round_robin_selector.sv
// Combinational rotating-priority search: first asserted request at or
// after i_ptr, wrapping at N. Shared with the router VC allocator.
module noc_round_robin_selector #(
    parameter  int N    = 4,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [N-1:0]    o_onehot,
    output logic [IDXW-1:0] o_idx,
    output logic            o_found
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        // Outer loop walks priority order; the pair of compares handles wrap.
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_found && i_req[j] &&
                    ((int'(i_ptr) + off == j) || (int'(i_ptr) + off == j + N))) begin
                    o_found     = 1'b1;
                    o_idx       = IDXW'(j);
                    o_onehot[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/noc_flit_arbiter.sv
// Packet-atomic round-robin arbiter: picks one requester per packet and
// forwards it through a zero-latency mux until its tail flit is accepted.
module noc_flit_arbiter
    import noc_bfm_types_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int FLIT_WIDTH = $bits(noc_bfm_flit)
) (
    input logic               clk,
    input logic               rst,
    noc_flit_arbiter_if.slave bus
);

    localparam int IDXW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TAIL_BIT = noc_flit_tail_bit(FLIT_WIDTH);

    arb_state_t            r_state, w_state_d;
    logic [IDXW-1:0]       r_ptr, w_ptr_d;
    logic [IDXW-1:0]       r_grant, w_grant_d;

    logic [CHANNELS-1:0]   w_sel_onehot;
    logic [IDXW-1:0]       w_sel_idx;
    logic                  w_sel_found;

    logic [IDXW-1:0]       w_src;
    logic [IDXW-1:0]       w_src_inc;
    logic [FLIT_WIDTH-1:0] w_src_flit;
    logic                  w_src_valid;
    logic                  w_active;
    logic                  w_xfer;
    logic                  w_tail_xfer;

    noc_round_robin_selector #(.N(CHANNELS)) u_sel (
        .i_req    (bus.i_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_sel_idx),
        .o_found  (w_sel_found)
    );

    // Source mux: live search result while idle, frozen grant while busy.
    always_comb begin
        w_src       = (r_state == ARB_IDLE) ? w_sel_idx : r_grant;
        w_active    = (r_state == ARB_BUSY) || w_sel_found;
        w_src_valid = 1'b0;
        w_src_flit  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(w_src) == k) begin
                w_src_valid = bus.i_valid[k];
                w_src_flit  = bus.i_flit[k*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
        w_xfer      = w_active && w_src_valid && bus.i_ready;
        w_tail_xfer = w_xfer && w_src_flit[TAIL_BIT];
        w_src_inc   = (int'(w_src) == CHANNELS - 1) ? '0 : w_src + 1'b1;
    end

    always_comb begin
        bus.o_valid = w_active && w_src_valid;
        bus.o_flit  = w_active ? w_src_flit : '0;
        bus.o_grant = '0;
        bus.o_ready = '0;
        if (r_state == ARB_IDLE) begin
            bus.o_grant = w_sel_onehot;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_active && int'(w_src) == k) begin
                bus.o_grant[k] = 1'b1;
                bus.o_ready[k] = bus.i_ready;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_grant_d = r_grant;
        case (r_state)
            ARB_IDLE: begin
                if (w_sel_found) begin
                    // A stalled or multi-flit offer freezes the choice.
                    if (w_tail_xfer) begin
                        w_ptr_d = w_src_inc;
                    end else begin
                        w_state_d = ARB_BUSY;
                        w_grant_d = w_src;
                    end
                end
            end
            ARB_BUSY: begin
                if (w_tail_xfer) begin
                    w_state_d = ARB_IDLE;
                    w_ptr_d   = w_src_inc;
                end
            end
            default: w_state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_grant <= w_grant_d;
        end
    end

endmodule

// File: tb/tb_noc_flit_arbiter.sv
// Bench for noc_flit_arbiter: directed vector table, hand-written stall,
// bubble and reset sequences, then random traffic against a packet model.
module tb_noc_flit_arbiter;
    import noc_bfm_types_pkg::*;

    localparam int CH   = 4;
    localparam int FW   = $bits(noc_bfm_flit);
    localparam int NPKT = 2500;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_flit_arbiter_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) bus ();
    noc_flit_arbiter #(.CHANNELS(CH), .FLIT_WIDTH(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [CH-1:0]         valid;
        logic                  ready;
        logic [CH-1:0][FW-1:0] flit;
        logic                  exp_valid;
        logic [CH-1:0]         exp_grant;
        logic [CH-1:0]         exp_ready;
        logic [FW-1:0]         exp_flit;
    } vec_t;

    vec_t vecs[$];
    logic [CH-1:0][FW-1:0] fa;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input bit head, input bit tail, input logic [15:0] d);
        noc_bfm_flit f;
        f.flit_type = head ? FLIT_HEAD : FLIT_PAYLOAD;
        f.tail      = tail;
        f.data      = d;
        return f;
    endfunction

    function automatic vec_t mkv(input logic [CH-1:0] va, input logic rd,
                                 input logic [CH-1:0][FW-1:0] fl, input logic ev,
                                 input logic [CH-1:0] eg, input logic [CH-1:0] er,
                                 input logic [FW-1:0] ef);
        vec_t v;
        v.valid = va; v.ready = rd; v.flit = fl;
        v.exp_valid = ev; v.exp_grant = eg; v.exp_ready = er; v.exp_flit = ef;
        return v;
    endfunction

    task automatic drive(input logic [CH-1:0] va, input logic rd, input logic [CH-1:0][FW-1:0] fl);
        bus.i_valid = va;
        bus.i_ready = rd;
        bus.i_flit  = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [CH-1:0] eg,
                              input logic [CH-1:0] er, input logic [FW-1:0] ef);
        @(negedge clk);
        chk({tag, ".valid"}, bus.o_valid, ev);
        chk({tag, ".grant"}, bus.o_grant, eg);
        chk({tag, ".ready"}, bus.o_ready, er);
        if (ev) chk({tag, ".flit"}, bus.o_flit, ef);
        next_cycle();
    endtask

    // Random-phase model state
    int len[CH], pos[CH], seqn[CH], left[CH], waitc[CH];
    bit acc[CH], waiting[CH];
    logic [CH-1:0] v;
    logic [CH-1:0][FW-1:0] drv_flit;
    logic [CH-1:0] eg;
    int owner, rrp, done, w;

    initial begin
        rst = 1'b1;
        drive('0, 1'b0, '0);
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset.valid", bus.o_valid, 1'b0);
        chk("reset.ready", bus.o_ready, '0);
        chk("reset.grant", bus.o_grant, '0);
        chk("reset.flit",  bus.o_flit,  '0);
        next_cycle();

        // Four single-flit packets, served 0..3, then pointer back at 0.
        for (int k = 0; k < CH; k++) fa[k] = mk(1, 1, 16'(16'h0100 + k));
        vecs.push_back(mkv(4'b1111, 1, fa, 1, 4'b0001, 4'b0001, fa[0]));
        vecs.push_back(mkv(4'b1110, 1, fa, 1, 4'b0010, 4'b0010, fa[1]));
        vecs.push_back(mkv(4'b1100, 1, fa, 1, 4'b0100, 4'b0100, fa[2]));
        vecs.push_back(mkv(4'b1000, 1, fa, 1, 4'b1000, 4'b1000, fa[3]));
        vecs.push_back(mkv(4'b1111, 1, fa, 1, 4'b0001, 4'b0001, fa[0]));
        vecs.push_back(mkv(4'b1110, 1, fa, 1, 4'b0010, 4'b0010, fa[1]));
        vecs.push_back(mkv(4'b1100, 1, fa, 1, 4'b0100, 4'b0100, fa[2]));
        vecs.push_back(mkv(4'b1000, 1, fa, 1, 4'b1000, 4'b1000, fa[3]));
        // Three-flit packet on 1 holds off input 2 until the tail.
        fa = '0;
        fa[2] = mk(1, 1, 16'h0220);
        fa[1] = mk(1, 0, 16'h0210);
        vecs.push_back(mkv(4'b0110, 1, fa, 1, 4'b0010, 4'b0010, fa[1]));
        fa[1] = mk(0, 0, 16'h0211);
        vecs.push_back(mkv(4'b0110, 1, fa, 1, 4'b0010, 4'b0010, fa[1]));
        fa[1] = mk(0, 1, 16'h0212);
        vecs.push_back(mkv(4'b0110, 1, fa, 1, 4'b0010, 4'b0010, fa[1]));
        vecs.push_back(mkv(4'b0100, 1, fa, 1, 4'b0100, 4'b0100, fa[2]));
        vecs.push_back(mkv(4'b0000, 1, fa, 0, 4'b0000, 4'b0000, '0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].ready, vecs[i].flit);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_grant,
                       vecs[i].exp_ready, vecs[i].exp_flit);
        end

        // Stalled offer from 3 (pointer now 3) stays frozen while 0 waits.
        fa = '0;
        fa[3] = mk(1, 1, 16'h0330);
        fa[0] = mk(1, 1, 16'h0300);
        for (int c = 0; c < 5; c++) begin
            drive((c == 0) ? 4'b1000 : 4'b1001, 1'b0, fa);
            expect_out($sformatf("stall%0d", c), 1, 4'b1000, 4'b0000, fa[3]);
        end
        drive(4'b1001, 1'b1, fa);
        expect_out("stall_release", 1, 4'b1000, 4'b1000, fa[3]);
        drive(4'b0001, 1'b1, fa);
        expect_out("stall_next", 1, 4'b0001, 4'b0001, fa[0]);

        // Bubble inside packet on 0 keeps input 1 blocked (pointer now 1).
        fa = '0;
        fa[0] = mk(1, 0, 16'h0400);
        fa[1] = mk(1, 1, 16'h0410);
        drive(4'b0001, 1'b1, fa);
        expect_out("bub_head", 1, 4'b0001, 4'b0001, fa[0]);
        fa[0] = mk(0, 0, 16'h0401);
        drive(4'b0011, 1'b1, fa);
        expect_out("bub_pay", 1, 4'b0001, 4'b0001, fa[0]);
        for (int c = 0; c < 2; c++) begin
            drive(4'b0010, 1'b1, fa);
            expect_out($sformatf("bub_gap%0d", c), 0, 4'b0001, 4'b0001, '0);
        end
        fa[0] = mk(0, 1, 16'h0402);
        drive(4'b0011, 1'b1, fa);
        expect_out("bub_tail", 1, 4'b0001, 4'b0001, fa[0]);
        drive(4'b0010, 1'b1, fa);
        expect_out("bub_in1", 1, 4'b0010, 4'b0010, fa[1]);

        // Reset while busy on 2; afterwards pointer is 0 so 1 beats 3.
        fa = '0;
        fa[2] = mk(1, 0, 16'h0520);
        drive(4'b0100, 1'b1, fa);
        expect_out("rst_busy", 1, 4'b0100, 4'b0100, fa[2]);
        rst = 1'b1;
        drive('0, 1'b1, fa);
        next_cycle();
        rst = 1'b0;
        expect_out("rst_idle", 0, 4'b0000, 4'b0000, '0);
        fa[1] = mk(1, 1, 16'h0510);
        fa[3] = mk(1, 1, 16'h0530);
        drive(4'b1010, 1'b1, fa);
        expect_out("rst_grant1", 1, 4'b0010, 4'b0010, fa[1]);
        drive(4'b1000, 1'b1, fa);
        expect_out("rst_grant3", 1, 4'b1000, 4'b1000, fa[3]);

        // Random traffic against a packet-level model.
        rst = 1'b1;
        drive('0, 1'b0, '0);
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < CH; k++) begin
            len[k] = 0; pos[k] = 0; seqn[k] = 0; left[k] = NPKT;
            waitc[k] = 0; acc[k] = 0; waiting[k] = 0;
        end
        v = '0; drv_flit = '0; owner = -1; rrp = 0; done = 0;

        for (int cyc = 0; cyc < 90000 && done < CH*NPKT; cyc++) begin
            for (int k = 0; k < CH; k++) begin
                if (acc[k]) begin
                    acc[k] = 0; v[k] = 0; pos[k]++; seqn[k]++;
                    if (pos[k] == len[k]) begin len[k] = 0; pos[k] = 0; end
                end
                if (!v[k]) begin
                    if (len[k] == 0 && left[k] > 0) begin
                        len[k] = $urandom_range(1, 3); pos[k] = 0; left[k]--;
                    end
                    if (len[k] != 0 && $urandom_range(0, 9) < 8) begin
                        v[k] = 1'b1;
                        drv_flit[k] = mk(pos[k] == 0, pos[k] == len[k] - 1,
                                         {4'(k), 12'(seqn[k])});
                        if (pos[k] == 0) begin waiting[k] = 1; waitc[k] = 0; end
                    end
                end
            end
            drive(v, ($urandom_range(0, 3) != 0), drv_flit);
            @(negedge clk);
            if (owner < 0) begin
                w = -1;
                for (int o = 0; o < CH; o++)
                    if (w < 0 && v[(rrp + o) % CH]) w = (rrp + o) % CH;
                if (w < 0) chk("rnd_idle", {bus.o_valid, bus.o_grant}, '0);
                else begin
                    owner = w;
                    chk("rnd_head", bus.o_flit[FW-1], 1'b1);
                end
            end
            if (owner >= 0) begin
                eg = '0;
                eg[owner] = 1'b1;
                chk("rnd_grant", bus.o_grant, eg);
                chk("rnd_valid", bus.o_valid, v[owner]);
                chk("rnd_ready", bus.o_ready, bus.i_ready ? eg : '0);
                if (v[owner]) chk("rnd_flit", bus.o_flit, drv_flit[owner]);
                if (v[owner] && bus.i_ready) begin
                    acc[owner] = 1;
                    if (pos[owner] == 0) begin
                        chk("rnd_starve", waitc[owner] > 3, 1'b0);
                        waiting[owner] = 0;
                    end
                    if (drv_flit[owner][FW-2]) begin
                        for (int k = 0; k < CH; k++)
                            if (k != owner && waiting[k]) waitc[k]++;
                        rrp = (owner + 1) % CH;
                        done++;
                        owner = -1;
                    end
                end
            end
            next_cycle();
        end
        chk("rnd_packets_done", done, CH*NPKT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
